ahbls_mem: RTL and testbench
============================

// Module: ahbls_mem
// PURPOSE
//  AHB-Lite subordinate: word-organised memory behind one hselx, byte-lane writes,
//  programmable wait states, two-cycle ERROR response for a configurable address window.
//  Sits at the other end of the bus from the ahblm master BFM; a synthesizable target
//  for the master's tasks (write32/read32/rdmwr/polling) and for bus-fabric benches.
// PARAMETERS
//  MEM_AW       8            word-address bits; depth = 2**MEM_AW 32-bit words
//  WAIT_STATES  0            hreadyout-low cycles inserted per OKAY data phase (0..15)
//  ERR_BASE     32'hFFFF_F000 base of ERROR window
//  ERR_MASK     32'hFFFF_F000 ERROR if (haddr & ERR_MASK) == ERR_BASE
// PORTS
//  hclk       in   1   clock, rising edge
//  hresetn    in   1   asynchronous, active-low reset
//  hselx      in   1   subordinate select
//  haddr      in   32  byte address (address phase)
//  htrans     in   2   IDLE/BUSY/NONSEQ/SEQ
//  hwrite     in   1   1 = write
//  hsize      in   3   transfer size; only BIT8/BIT16/BIT32 legal
//  hburst     in   3   ignored (each beat decoded independently)
//  hprot      in   4   ignored
//  hmastlock  in   1   ignored
//  hwdata     in   32  write data (data phase)
//  hrdata     out  32  read data (data phase)
//  hready     in   1   bus ready; address phase accepted only when 1
//  hreadyout  out  1   0 = extend current data phase
//  hresp      out  1   0 OKAY, 1 ERROR
// BEHAVIOUR
//  - Reset: hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, no data phase pending.
//    Memory array NOT reset; contents retained across reset.
//  - Accept: posedge with hselx & hready & htrans[1] (NONSEQ/SEQ) registers addr,
//    hwrite, hsize, index = haddr[MEM_AW+1:2] (upper bits alias/wrap).
//    IDLE/BUSY or !hselx: zero-wait OKAY, no access.
//  - Error decode at accept: ERR window hit, hsize>BIT32, or misaligned
//    (BIT16 & haddr[0], BIT32 & haddr[1:0]!=0) -> ERROR path.
//  - FSM states: IDLE, WAIT, ERR1, ERR2.
//    IDLE: accept OK & WAIT_STATES>0 -> WAIT (cnt=WAIT_STATES-1), hreadyout=0.
//          accept OK & WAIT_STATES==0 -> stays IDLE, data phase next cycle, hreadyout=1.
//          accept ERR -> ERR1.
//    WAIT: hreadyout=0, hresp=0; cnt==0 -> IDLE (completing cycle, hreadyout=1) else cnt-1.
//    ERR1: hreadyout=0, hresp=1 -> ERR2.  ERR2: hreadyout=1, hresp=1 -> IDLE.
//    ERROR path ignores WAIT_STATES; errored write never modifies memory.
//  - New address phase sampled in any cycle where hready=1 (incl. final WAIT/ERR2 cycle),
//    giving back-to-back pipelining with no bubble.
//  - Write: byte enables from hsize/addr[1:0] (lane = addr[1:0] for BIT8, addr[1]*2 for
//    BIT16); array written at posedge ending the data phase (hreadyout=1) from hwdata.
//  - Read: hrdata = array[index] combinationally from registered index, valid whenever a
//    read data phase is active; 0 otherwise. Full 32-bit word returned for all sizes.
//  - Read directly after write to same word (pipelined): returns new data.
//  - Reset asserted mid-transfer: pending phase dropped, outputs to reset values next
//    instant; in-flight write not performed.
// STRUCTURE
//  - ahb_pkg: HTRANS_*, HSIZE_*, HBURST_*, HRESP_* constants, FSM state typedef;
//    shared with ahblm.
//  - Sub-module ahbls_ram: 2**MEM_AW x 32, 4 byte-enables, sync write, async read.
//  - Top: address-phase register, error decode, wait counter/FSM, byte-enable logic.
// TESTING (ahblm as driver, check hreadyout/hresp per cycle)
//  1 WAIT_STATES=0: write32(0x10,0xDEADBEEF); read32(0x10) -> 0xDEADBEEF, hreadyout
//    never 0.
//  2 WAIT_STATES=3: read32 -> exactly 3 hreadyout-low cycles, then data, hresp=0.
//  3 Byte write 0xAA to 0x13 over 0x11223344 at 0x10 -> read 0xAA223344.
//  4 write32(0xFFFF_F004,0x1) -> ERR1 (ready0,resp1), ERR2 (ready1,resp1), ahblm reports
//    hresp; following read32(0x04) OKAY, memory unchanged.
//  5 Misaligned BIT32 at 0x02 -> ERROR; hsize=BIT64 -> ERROR.
//  6 Reset asserted during WAIT of a write to 0x20 -> hreadyout=1 immediately;
//    read32(0x20) after release returns prior value.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB-Lite protocol constants and subordinate FSM encoding shared by bus agents.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BIT8    = 3'b000;
    localparam logic [2:0] HSIZE_BIT16   = 3'b001;
    localparam logic [2:0] HSIZE_BIT32   = 3'b010;
    localparam logic [2:0] HSIZE_BIT64   = 3'b011;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_ERR1 = 2'd2;
    localparam state_t ST_ERR2 = 2'd3;

    // Byte lanes touched by a legal (aligned) transfer of the given size.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            HSIZE_BIT8:  be = 4'b0001 << lane;
            HSIZE_BIT16: be = lane[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahbls_ram.sv
// Word-organised storage: synchronous byte-enabled write, asynchronous read.
module ahbls_ram #(
    parameter int unsigned AW = 8
) (
    input  logic          hclk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [31:0] mem [DEPTH];

    // Byte-lane write; contents are deliberately not reset.
    always_ff @(posedge hclk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahbls_mem.sv
// AHB-Lite memory subordinate with programmable wait states and an ERROR address window.
module ahbls_mem
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_AW      = 8,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ERR_BASE    = 32'hFFFF_F000,
    parameter logic [31:0] ERR_MASK    = 32'hFFFF_F000
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hselx,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic        hmastlock,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int unsigned CNT_W = 4;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dp_valid_q, dp_valid_d;
    logic                dp_write_q, dp_write_d;
    logic [MEM_AW-1:0]   dp_index_q, dp_index_d;
    logic [3:0]          dp_be_q, dp_be_d;
    logic                hreadyout_d;
    logic                hresp_d;

    logic                accept_c;
    logic                decode_err_c;
    logic                ram_we_c;
    logic [31:0]         ram_rdata_c;
    logic                unused_ok;

    assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0]};

    assign accept_c = hselx & hready & htrans[1];

    // Window hit, oversize or misaligned transfers take the two-cycle ERROR path.
    assign decode_err_c = ((haddr & ERR_MASK) == ERR_BASE)
                        | (hsize > HSIZE_BIT32)
                        | ((hsize == HSIZE_BIT16) & haddr[0])
                        | ((hsize == HSIZE_BIT32) & (|haddr[1:0]));

    // Next-state, address-phase capture and registered response decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_index_d = dp_index_q;
        dp_be_d    = dp_be_q;

        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (hready) begin
                    state_d    = ST_IDLE;
                    dp_valid_d = 1'b0;
                    if (accept_c) begin
                        if (decode_err_c) begin
                            state_d = ST_ERR1;
                        end else begin
                            dp_valid_d = 1'b1;
                            dp_write_d = hwrite;
                            dp_index_d = haddr[MEM_AW+1:2];
                            dp_be_d    = byte_en(hsize, haddr[1:0]);
                            if (WAIT_STATES != 0) begin
                                state_d = ST_WAIT;
                                cnt_d   = CNT_W'(WAIT_STATES - 1);
                            end
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hreadyout_d = (state_d == ST_IDLE) | (state_d == ST_ERR2);
        hresp_d     = (state_d == ST_ERR1) | (state_d == ST_ERR2);
    end

    // State and data-phase registers; a reset drops any pending phase.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_index_q <= '0;
            dp_be_q    <= '0;
            hreadyout  <= 1'b1;
            hresp      <= HRESP_OKAY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_index_q <= dp_index_d;
            dp_be_q    <= dp_be_d;
            hreadyout  <= hreadyout_d;
            hresp      <= hresp_d;
        end
    end

    // Write commits on the edge that ends an OKAY write data phase.
    assign ram_we_c = dp_valid_q & dp_write_q & hreadyout & hready;

    ahbls_ram #(
        .AW(MEM_AW)
    ) u_ram (
        .hclk  (hclk),
        .we    (ram_we_c),
        .be    (dp_be_q),
        .addr  (dp_index_q),
        .wdata (hwdata),
        .rdata (ram_rdata_c)
    );

    assign hrdata = (dp_valid_q & ~dp_write_q) ? ram_rdata_c : 32'h0;

endmodule

// File: tb/tb_ahbls_mem.sv
// Randomised scoreboard bench: two subordinates (0 and 3 wait states) on one shared bus.
module tb_ahbls_mem;
    import ahb_pkg::*;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [2:0]  hburst = HBURST_SINGLE;
    logic [3:0]  hprot = 4'b0011;
    logic        hmastlock = 1'b0;
    int          sel = 0;

    logic [31:0] hrdata0, hrdata1, hrdata;
    logic        ro0, ro1, hready;
    logic        resp0, resp1, hresp;

    always #5 hclk = ~hclk;

    assign hready = (sel == 1) ? ro1 : ro0;
    assign hresp  = (sel == 1) ? resp1 : resp0;
    assign hrdata = (sel == 1) ? hrdata1 : hrdata0;

    ahbls_mem #(.MEM_AW(8), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hselx(hsel && sel == 0), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hmastlock(hmastlock), .hwdata(hwdata), .hrdata(hrdata0), .hready(hready),
        .hreadyout(ro0), .hresp(resp0)
    );

    ahbls_mem #(.MEM_AW(8), .WAIT_STATES(3)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .hselx(hsel && sel == 1), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hmastlock(hmastlock), .hwdata(hwdata), .hrdata(hrdata1), .hready(hready),
        .hreadyout(ro1), .hresp(resp1)
    );

    typedef struct {
        bit          rd;
        bit          err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  mb [2][1024];
    int          ws_of [2] = '{0, 3};
    int          n_tests = 0;
    int          n_fail = 0;
    bit          in_dp = 0;
    int          waits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
        int unsigned nb;
        if ((a & 32'hFFFF_F000) == 32'hFFFF_F000) return 1'b1;
        if (s > 3'd2) return 1'b1;
        nb = 1 << s;
        return (a % nb) != 0;
    endfunction

    // One transfer: model update + expectation push, then address phase until accepted.
    task automatic xfer(input logic [31:0] a, input bit wr, input logic [2:0] s,
                        input logic [31:0] wd, input bit track);
        exp_t        e;
        int unsigned ba;
        int unsigned wb;
        int          k;
        e.rd    = !wr;
        e.err   = is_err(a, s);
        e.data  = 32'h0;
        e.waits = e.err ? 1 : ws_of[sel];
        if (track && !e.err) begin
            if (wr) begin
                for (int i = 0; i < (1 << s); i++) begin
                    ba = (int'(a[9:0]) + i) % 1024;
                    mb[sel][ba] = wd[8*(ba % 4) +: 8];
                end
            end else begin
                wb = int'(a[9:0]) / 4 * 4;
                e.data = {mb[sel][wb+3], mb[sel][wb+2], mb[sel][wb+1], mb[sel][wb]};
            end
        end
        if (track) sbq.push_back(e);
        hsel   = 1'b1;
        haddr  = a;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        hsize  = s;
        k = 0;
        do begin
            @(negedge hclk);
            k++;
        end while (!hready && k < 100);
        if (!hready) check("accept_timeout", 32'(hready), 32'h1);
        @(posedge hclk);
        #1;
        hwdata = wd;
        htrans = HTRANS_IDLE;
    endtask

    task automatic drain();
        int k = 0;
        while ((sbq.size() != 0 || in_dp) && k < 200) begin
            @(negedge hclk);
            k++;
        end
        check("drain_pending", 32'(sbq.size()), 32'h0);
        @(posedge hclk);
        #1;
    endtask

    // Monitor: tracks bus data phases independently of the driver and scores completions.
    always @(negedge hclk) begin
        exp_t e;
        if (!hresetn) begin
            in_dp = 1'b0;
            waits = 0;
        end else begin
            if (in_dp) begin
                if (!hready) begin
                    waits++;
                    if (sbq.size() != 0) check("wait_hresp", 32'(hresp), 32'(sbq[0].err));
                end else begin
                    if (sbq.size() == 0) begin
                        check("scoreboard_empty", 32'h1, 32'h0);
                    end else begin
                        e = sbq.pop_front();
                        check("hresp", 32'(hresp), 32'(e.err));
                        check("wait_cycles", 32'(waits), 32'(e.waits));
                        if (e.rd && !e.err) check("hrdata", hrdata, e.data);
                    end
                    in_dp = 1'b0;
                    waits = 0;
                end
            end
            if (hready && hsel && htrans[1]) begin
                in_dp = 1'b1;
                waits = 0;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  s;
        int          r;
        hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        hsize = HSIZE_BIT32; hwdata = '0;

        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check("rst_hreadyout0", 32'(ro0), 32'h1);
        check("rst_hreadyout1", 32'(ro1), 32'h1);
        check("rst_hresp0", 32'(resp0), 32'h0);
        check("rst_hresp1", 32'(resp1), 32'h0);
        check("rst_hrdata0", hrdata0, 32'h0);
        check("rst_hrdata1", hrdata1, 32'h0);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;

        // Give both memories known contents in the low 64 words.
        for (int d = 0; d < 2; d++) begin
            sel = d;
            for (int w = 0; w < 64; w++) xfer(32'(w * 4), 1'b1, HSIZE_BIT32, $urandom, 1'b1);
            drain();
        end

        // Zero-wait write then pipelined read of the same word.
        sel = 0;
        xfer(32'h10, 1'b1, HSIZE_BIT32, 32'hDEAD_BEEF, 1'b1);
        xfer(32'h10, 1'b0, HSIZE_BIT32, 32'h0, 1'b1);
        drain();

        // Three wait states, byte and halfword lanes, error window, misalignment, oversize.
        sel = 1;
        xfer(32'h10, 1'b1, HSIZE_BIT32, 32'h1122_3344, 1'b1);
        xfer(32'h10, 1'b0, HSIZE_BIT32, 32'h0, 1'b1);
        xfer(32'h13, 1'b1, HSIZE_BIT8, 32'hAA00_0000, 1'b1);
        xfer(32'h10, 1'b0, HSIZE_BIT32, 32'h0, 1'b1);
        xfer(32'h12, 1'b1, HSIZE_BIT16, 32'h5566_0000, 1'b1);
        xfer(32'h10, 1'b0, HSIZE_BIT8, 32'h0, 1'b1);
        xfer(32'hFFFF_F004, 1'b1, HSIZE_BIT32, 32'h1, 1'b1);
        xfer(32'h04, 1'b0, HSIZE_BIT32, 32'h0, 1'b1);
        xfer(32'h02, 1'b1, HSIZE_BIT32, 32'hFFFF_FFFF, 1'b1);
        xfer(32'h00, 1'b1, HSIZE_BIT64, 32'hFFFF_FFFF, 1'b1);
        xfer(32'h01, 1'b1, HSIZE_BIT16, 32'hFFFF_FFFF, 1'b1);
        xfer(32'h00, 1'b0, HSIZE_BIT32, 32'h0, 1'b1);
        drain();

        // Reset during the wait states of a write: write is lost, memory retained.
        xfer(32'h20, 1'b1, HSIZE_BIT32, 32'h5A5A_1234, 1'b1);
        drain();
        xfer(32'h20, 1'b1, HSIZE_BIT32, 32'hFFFF_0000, 1'b0);
        @(negedge hclk);
        check("wait_hreadyout_low", 32'(ro1), 32'h0);
        #2;
        hresetn = 1'b0;
        #1;
        check("midrst_hreadyout", 32'(ro1), 32'h1);
        check("midrst_hresp", 32'(resp1), 32'h0);
        check("midrst_hrdata", hrdata1, 32'h0);
        @(posedge hclk);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        xfer(32'h20, 1'b0, HSIZE_BIT32, 32'h0, 1'b1);
        drain();

        // Random mix of sizes, lanes, aliases, errors and idle gaps on each subordinate.
        for (int d = 0; d < 2; d++) begin
            sel = d;
            for (int n = 0; n < 150; n++) begin
                r = $urandom_range(0, 20);
                s = (r == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                r = $urandom_range(0, 15);
                if (r == 0) begin
                    a = 32'hFFFF_F000 | ($urandom & 32'h0000_0FFC);
                end else begin
                    a = 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3) * 32'h400);
                    if (r == 1) a = a + 32'($urandom_range(0, 3));
                    else if (s == HSIZE_BIT8) a = a + 32'($urandom_range(0, 3));
                    else if (s == HSIZE_BIT16) a = a + 32'($urandom_range(0, 1) * 2);
                end
                xfer(a, 1'($urandom_range(0, 1)), s, $urandom, 1'b1);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge hclk);
                    #1;
                end
            end
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
